// File: rtl/ei_tdp_ram_pkg.sv
// Shared definitions for the ei_tdp_ram_pipe true-dual-port RAM: FSM state
// encoding, legal read latencies and the per-byte parity helper.
package ei_tdp_ram_pkg;

  typedef enum logic [1:0] {
    RESET = 2'd0,
    CLEAR = 2'd1,
    RUN   = 2'd2
  } ram_state_e;

  localparam int RD_LATENCY_MIN = 1;
  localparam int RD_LATENCY_MAX = 2;

  // Even parity: the stored bit makes the byte plus parity an even popcount.
  function automatic logic even_parity8(input logic [7:0] byte_val);
    return ^byte_val;
  endfunction

endpackage

// File: rtl/ei_tdp_ram_rd_pipe.sv
// Per-port read pipeline: carries read data, valid and parity-error flag
// through RD_LATENCY register stages; q holds its value between reads.
module ei_tdp_ram_rd_pipe
  import ei_tdp_ram_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int RD_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  req,
  input  logic [DATA_WIDTH-1:0] rd_data,
  input  logic                  rd_par_err,
  output logic [DATA_WIDTH-1:0] q,
  output logic                  rvalid,
  output logic                  par_err
);

  logic                  s1_valid;
  logic                  s1_err;
  logic [DATA_WIDTH-1:0] s1_data;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      s1_valid <= 1'b0;
      s1_err   <= 1'b0;
      s1_data  <= '0;
    end else begin
      s1_valid <= req;
      s1_err   <= req & rd_par_err;
      if (req) begin
        s1_data <= rd_data;
      end
    end
  end

  generate
    if (RD_LATENCY >= RD_LATENCY_MAX) begin : g_lat2
      logic                  s2_valid;
      logic                  s2_err;
      logic [DATA_WIDTH-1:0] s2_data;

      always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
          s2_valid <= 1'b0;
          s2_err   <= 1'b0;
          s2_data  <= '0;
        end else begin
          s2_valid <= s1_valid;
          s2_err   <= s1_valid & s1_err;
          if (s1_valid) begin
            s2_data <= s1_data;
          end
        end
      end

      assign q       = s2_data;
      assign rvalid  = s2_valid;
      assign par_err = s2_err;
    end else begin : g_lat1
      assign q       = s1_data;
      assign rvalid  = s1_valid;
      assign par_err = s1_err;
    end
  endgenerate

endmodule

// File: rtl/ei_tdp_ram_pipe.sv
// True-dual-port byte-writable RAM with self-clear after reset and pipelined
// reads. Define TDP_RAM_PARITY_EN to add per-byte even parity storage/check.
module ei_tdp_ram_pipe
  import ei_tdp_ram_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10,
  parameter int RD_LATENCY = 1
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic [DATA_WIDTH-1:0]   data_a,
  input  logic [DATA_WIDTH-1:0]   data_b,
  input  logic [ADDR_WIDTH-1:0]   addr_a,
  input  logic [ADDR_WIDTH-1:0]   addr_b,
  input  logic                    we_a,
  input  logic                    we_b,
  input  logic [DATA_WIDTH/8-1:0] be_a,
  input  logic [DATA_WIDTH/8-1:0] be_b,
  input  logic                    re_a,
  input  logic                    re_b,
  output logic [DATA_WIDTH-1:0]   q_a,
  output logic [DATA_WIDTH-1:0]   q_b,
  output logic                    rvalid_a,
  output logic                    rvalid_b,
  output logic                    init_done,
  output logic                    collision,
  output logic                    par_err_a,
  output logic                    par_err_b
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam int NB    = DATA_WIDTH / 8;

  ram_state_e            state;
  logic [ADDR_WIDTH-1:0] clr_addr;
  logic                  run;
  logic                  clear_en;
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic                  rd_perr_a;
  logic                  rd_perr_b;

  assign run       = (state == RUN);
  assign init_done = run;
  // The first edge after reset release already clears address 0, so the
  // clear sweep finishes exactly DEPTH edges after release.
  assign clear_en  = resetn && (state != RUN);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state    <= RESET;
      clr_addr <= '0;
    end else begin
      case (state)
        RESET, CLEAR: begin
          clr_addr <= clr_addr + 1'b1;
          state    <= (clr_addr == '1) ? RUN : CLEAR;
        end
        RUN:     state <= RUN;
        default: state <= RESET;
      endcase
    end
  end

  // Port B bytes are written first so port A wins any overlapping byte.
  always_ff @(posedge clk) begin
    if (clear_en) begin
      mem[clr_addr] <= '0;
    end else if (run) begin
      for (int i = 0; i < NB; i++) begin
        if (we_b && be_b[i]) begin
          mem[addr_b][8*i +: 8] <= data_b[8*i +: 8];
        end
        if (we_a && be_a[i]) begin
          mem[addr_a][8*i +: 8] <= data_a[8*i +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      collision <= 1'b0;
    end else begin
      collision <= run && we_a && we_b && (addr_a == addr_b) && (|(be_a & be_b));
    end
  end

`ifdef TDP_RAM_PARITY_EN
  logic [NB-1:0] par_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (clear_en) begin
      par_mem[clr_addr] <= '0;
    end else if (run) begin
      for (int i = 0; i < NB; i++) begin
        if (we_b && be_b[i]) begin
          par_mem[addr_b][i] <= even_parity8(data_b[8*i +: 8]);
        end
        if (we_a && be_a[i]) begin
          par_mem[addr_a][i] <= even_parity8(data_a[8*i +: 8]);
        end
      end
    end
  end

  always_comb begin
    rd_perr_a = 1'b0;
    rd_perr_b = 1'b0;
    for (int i = 0; i < NB; i++) begin
      rd_perr_a = rd_perr_a | (par_mem[addr_a][i] ^ even_parity8(mem[addr_a][8*i +: 8]));
      rd_perr_b = rd_perr_b | (par_mem[addr_b][i] ^ even_parity8(mem[addr_b][8*i +: 8]));
    end
  end
`else
  assign rd_perr_a = 1'b0;
  assign rd_perr_b = 1'b0;
`endif

  ei_tdp_ram_rd_pipe #(
    .DATA_WIDTH (DATA_WIDTH),
    .RD_LATENCY (RD_LATENCY)
  ) u_rd_pipe_a (
    .clk        (clk),
    .resetn     (resetn),
    .req        (run && re_a),
    .rd_data    (mem[addr_a]),
    .rd_par_err (rd_perr_a),
    .q          (q_a),
    .rvalid     (rvalid_a),
    .par_err    (par_err_a)
  );

  ei_tdp_ram_rd_pipe #(
    .DATA_WIDTH (DATA_WIDTH),
    .RD_LATENCY (RD_LATENCY)
  ) u_rd_pipe_b (
    .clk        (clk),
    .resetn     (resetn),
    .req        (run && re_b),
    .rd_data    (mem[addr_b]),
    .rd_par_err (rd_perr_b),
    .q          (q_b),
    .rvalid     (rvalid_b),
    .par_err    (par_err_b)
  );

endmodule

// File: tb/tb_ei_tdp_ram_pipe.sv
// Self-checking bench for ei_tdp_ram_pipe (ADDR_WIDTH=4, RD_LATENCY=2) with a
// behavioural memory model; parity backdoor test needs TDP_RAM_PARITY_EN.
module tb_ei_tdp_ram_pipe;

  localparam int DW     = 32;
  localparam int AW     = 4;
  localparam int RD_LAT = 2;
  localparam int DEPTH  = 16;

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic [DW-1:0] data_a, data_b;
  logic [AW-1:0] addr_a, addr_b;
  logic          we_a, we_b, re_a, re_b;
  logic [3:0]    be_a, be_b;
  logic [DW-1:0] q_a, q_b;
  logic          rvalid_a, rvalid_b, init_done, collision, par_err_a, par_err_b;

  always #5 clk = ~clk;

  ei_tdp_ram_pipe #(
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW),
    .RD_LATENCY (RD_LAT)
  ) dut (
    .clk       (clk),
    .resetn    (resetn),
    .data_a    (data_a),
    .data_b    (data_b),
    .addr_a    (addr_a),
    .addr_b    (addr_b),
    .we_a      (we_a),
    .we_b      (we_b),
    .be_a      (be_a),
    .be_b      (be_b),
    .re_a      (re_a),
    .re_b      (re_b),
    .q_a       (q_a),
    .q_b       (q_b),
    .rvalid_a  (rvalid_a),
    .rvalid_b  (rvalid_b),
    .init_done (init_done),
    .collision (collision),
    .par_err_a (par_err_a),
    .par_err_b (par_err_b)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: an array of words, a clear counter and per-port queues
  // of pending read results tagged with the edge on which they must appear.
  typedef struct {
    int          due;
    logic [31:0] data;
    logic        err;
  } rd_t;

  logic [31:0] m_mem [DEPTH];
  logic [3:0]  m_bad [DEPTH];
  int          m_clr;
  bit          m_run;
  int          edge_n;
  rd_t         qa[$];
  rd_t         qb[$];
  logic [31:0] exp_q_a, exp_q_b;
  logic        exp_rv_a, exp_rv_b, exp_pe_a, exp_pe_b, exp_init, exp_coll;

  function automatic logic [31:0] byte_mask(input logic [3:0] be);
    logic [31:0] m;
    for (int i = 0; i < 4; i++) m[8*i +: 8] = {8{be[i]}};
    return m;
  endfunction

  task automatic model_reset();
    m_run = 0;
    m_clr = 0;
    qa.delete();
    qb.delete();
    exp_q_a = '0; exp_q_b = '0;
    exp_rv_a = 0; exp_rv_b = 0; exp_pe_a = 0; exp_pe_b = 0;
    exp_init = 0; exp_coll = 0;
  endtask

  task automatic model_step();
    logic [31:0] ma, mb;
    edge_n++;
    exp_rv_a = 0; exp_rv_b = 0; exp_pe_a = 0; exp_pe_b = 0; exp_coll = 0;
    if (m_run) begin
      if (re_a) qa.push_back('{due: edge_n + RD_LAT - 1, data: m_mem[addr_a], err: |m_bad[addr_a]});
      if (re_b) qb.push_back('{due: edge_n + RD_LAT - 1, data: m_mem[addr_b], err: |m_bad[addr_b]});
      ma = we_a ? byte_mask(be_a) : 32'h0;
      mb = we_b ? byte_mask(be_b) : 32'h0;
      m_mem[addr_b] = (m_mem[addr_b] & ~mb) | (data_b & mb);
      if (we_b) m_bad[addr_b] = m_bad[addr_b] & ~be_b;
      m_mem[addr_a] = (m_mem[addr_a] & ~ma) | (data_a & ma);
      if (we_a) m_bad[addr_a] = m_bad[addr_a] & ~be_a;
      exp_coll = we_a && we_b && (addr_a == addr_b) && ((be_a & be_b) != 4'h0);
    end else begin
      m_mem[m_clr] = '0;
      m_bad[m_clr] = '0;
      m_clr++;
      if (m_clr == DEPTH) m_run = 1;
    end
    exp_init = m_run;
    if (qa.size() > 0 && qa[0].due == edge_n) begin
      exp_rv_a = 1; exp_q_a = qa[0].data; exp_pe_a = qa[0].err;
      void'(qa.pop_front());
    end
    if (qb.size() > 0 && qb[0].due == edge_n) begin
      exp_rv_b = 1; exp_q_b = qb[0].data; exp_pe_b = qb[0].err;
      void'(qb.pop_front());
    end
  endtask

  always @(negedge resetn) model_reset();

  always @(posedge clk) begin
    if (!resetn) model_reset();
    else model_step();
  end

  always @(negedge clk) begin
    check_output("q_a", q_a, exp_q_a);
    check_output("q_b", q_b, exp_q_b);
    check_output("rvalid_a", 32'(rvalid_a), 32'(exp_rv_a));
    check_output("rvalid_b", 32'(rvalid_b), 32'(exp_rv_b));
    check_output("par_err_a", 32'(par_err_a), 32'(exp_pe_a));
    check_output("par_err_b", 32'(par_err_b), 32'(exp_pe_b));
    check_output("init_done", 32'(init_done), 32'(exp_init));
    check_output("collision", 32'(collision), 32'(exp_coll));
  end

  task automatic apply_stimulus(input logic wa, input logic [3:0] aa, input logic [31:0] da,
                                input logic [3:0] bea, input logic ra,
                                input logic wb, input logic [3:0] ab, input logic [31:0] db,
                                input logic [3:0] beb, input logic rb);
    we_a = wa; addr_a = aa; data_a = da; be_a = bea; re_a = ra;
    we_b = wb; addr_b = ab; data_b = db; be_b = beb; re_b = rb;
  endtask

  task automatic idle();
    apply_stimulus(0, 4'd0, 32'h0, 4'h0, 0, 0, 4'd0, 32'h0, 4'h0, 0);
  endtask

  task automatic release_and_wait_init(input string tag);
    #2 resetn = 1'b1;
    repeat (15) @(negedge clk);
    check_output({tag, "_init_early"}, 32'(init_done), 32'd0);
    @(negedge clk);
    check_output({tag, "_init_16"}, 32'(init_done), 32'd1);
  endtask

  task automatic assert_reset_check(input string tag);
    #2 resetn = 1'b0;
    #1;
    check_output({tag, "_rst_rvalid_a"}, 32'(rvalid_a), 32'd0);
    check_output({tag, "_rst_q_a"}, q_a, 32'h0);
    check_output({tag, "_rst_init"}, 32'(init_done), 32'd0);
  endtask

  initial begin
    edge_n = 0;
    model_reset();
    idle();
    repeat (3) @(negedge clk);
    check_output("reset_init_done", 32'(init_done), 32'd0);
    check_output("reset_q_b", q_b, 32'h0);
    release_and_wait_init("first");

    apply_stimulus(0, 4'd0, 32'h0, 4'h0, 0, 0, 4'd0, 32'h0, 4'h0, 0);
    apply_stimulus(0, 4'd9, 32'h0, 4'h0, 1, 0, 4'd0, 32'h0, 4'h0, 0);
    @(negedge clk); idle();
    @(negedge clk);
    check_output("clear_read_rvalid", 32'(rvalid_a), 32'd1);
    check_output("clear_read_q", q_a, 32'h0);

    apply_stimulus(1, 4'd5, 32'hDEADBEEF, 4'b0101, 0, 0, 4'd0, 32'h0, 4'h0, 0);
    @(negedge clk);
    apply_stimulus(0, 4'd0, 32'h0, 4'h0, 0, 0, 4'd5, 32'h0, 4'h0, 1);
    @(negedge clk); idle();
    check_output("be_read_early", 32'(rvalid_b), 32'd0);
    @(negedge clk);
    check_output("be_read_rvalid", 32'(rvalid_b), 32'd1);
    check_output("be_read_q", q_b, 32'h00AD00EF);

    apply_stimulus(1, 4'd7, 32'h11111111, 4'hF, 0, 1, 4'd7, 32'h22222222, 4'hF, 0);
    @(negedge clk);
    check_output("coll_pulse", 32'(collision), 32'd1);
    apply_stimulus(0, 4'd7, 32'h0, 4'h0, 1, 0, 4'd0, 32'h0, 4'h0, 0);
    @(negedge clk); idle();
    check_output("coll_once", 32'(collision), 32'd0);
    @(negedge clk);
    check_output("coll_read", q_a, 32'h11111111);

    apply_stimulus(1, 4'd3, 32'h000000AA, 4'hF, 0, 0, 4'd0, 32'h0, 4'h0, 0);
    @(negedge clk);
    apply_stimulus(1, 4'd3, 32'h00000055, 4'hF, 1, 0, 4'd0, 32'h0, 4'h0, 0);
    @(negedge clk);
    apply_stimulus(0, 4'd3, 32'h0, 4'h0, 1, 0, 4'd0, 32'h0, 4'h0, 0);
    @(negedge clk); idle();
    check_output("rw_old_q", q_a, 32'h000000AA);
    @(negedge clk);
    check_output("rw_new_q", q_a, 32'h00000055);

`ifdef TDP_RAM_PARITY_EN
    apply_stimulus(1, 4'd2, 32'h12345678, 4'hF, 0, 0, 4'd0, 32'h0, 4'h0, 0);
    @(negedge clk); idle();
    dut.par_mem[2][1] = ~dut.par_mem[2][1];
    m_bad[2][1] = 1'b1;
    apply_stimulus(0, 4'd2, 32'h0, 4'h0, 1, 0, 4'd0, 32'h0, 4'h0, 0);
    @(negedge clk); idle();
    @(negedge clk);
    check_output("par_rvalid", 32'(rvalid_a), 32'd1);
    check_output("par_err", 32'(par_err_a), 32'd1);
`endif

    for (int n = 0; n < 400; n++) begin
      apply_stimulus(($urandom_range(0, 2) == 0), 4'($urandom_range(0, 15)), $urandom,
                     4'($urandom_range(0, 15)), $urandom_range(0, 1) == 1,
                     ($urandom_range(0, 2) == 0), 4'($urandom_range(0, 15)), $urandom,
                     4'($urandom_range(0, 15)), $urandom_range(0, 1) == 1);
      if ($urandom_range(0, 3) == 0) addr_b = addr_a;
      @(negedge clk);
    end
    idle();
    repeat (3) @(negedge clk);

    apply_stimulus(0, 4'd7, 32'h0, 4'h0, 1, 0, 4'd7, 32'h0, 4'h0, 1);
    @(negedge clk); idle();
    assert_reset_check("midread");
    repeat (4) @(negedge clk);
    release_and_wait_init("after_read_rst");

    apply_stimulus(1, 4'd15, 32'hCAFEF00D, 4'hF, 0, 0, 4'd0, 32'h0, 4'h0, 0);
    @(negedge clk); idle();
    @(negedge clk);
    assert_reset_check("preclear");
    #2 resetn = 1'b1;
    repeat (5) @(negedge clk);
    assert_reset_check("midclear");
    repeat (2) @(negedge clk);
    release_and_wait_init("after_clear_rst");

    apply_stimulus(0, 4'd15, 32'h0, 4'h0, 1, 0, 4'd0, 32'h0, 4'h0, 0);
    @(negedge clk); idle();
    @(negedge clk);
    check_output("restart_clear_q", q_a, 32'h0);
    check_output("restart_clear_rvalid", 32'(rvalid_a), 32'd1);
    repeat (3) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
